// File: rtl/itrx_aib_phy_rst_seq.sv
// itrx_aib_phy_rst_seq
// Link reset sequencer for one AIB channel. It watches link presence and the
// remote PHY's reset handshakes, then releases adapt_rstn, rstn_in and
// adap_rstn_in in AIB order. It handles debounce, fixed release delays,
// handshake timeouts, link loss and software restart.
module itrx_aib_phy_rst_seq #(
    parameter int CNTW     = 16,
    parameter int DBNC_CYC = 16,
    parameter int PHY_DLY  = 8,
    parameter int ADAP_DLY = 8,
    parameter int TMO_CYC  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ms_nsl,
    input  logic       restart,
    input  logic       por_out,
    input  logic       device_detect,
    input  logic       rstn_out,
    input  logic       adap_rstn_out,
    output logic       adapt_rstn,
    output logic       rstn_in,
    output logic       adap_rstn_in,
    output logic       link_up,
    output logic       seq_err,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LINK = 3'd1,
        ST_PHY_RST   = 3'd2,
        ST_RSTN_REL  = 3'd3,
        ST_ADAP_DLY  = 3'd4,
        ST_ADAP_REL  = 3'd5,
        ST_LINK_UP   = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    // Terminal counts: each wait ends on the cycle its counter shows N-1.
    localparam logic [CNTW-1:0] DBNC_LAST = CNTW'(DBNC_CYC - 1);
    localparam logic [CNTW-1:0] PHY_LAST  = CNTW'(PHY_DLY - 1);
    localparam logic [CNTW-1:0] ADAP_LAST = CNTW'(ADAP_DLY - 1);
    localparam logic [CNTW-1:0] TMO_LAST  = CNTW'(TMO_CYC - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};

    logic [1:0] por_sync_q;
    logic [1:0] det_sync_q;
    logic [1:0] rstn_sync_q;
    logic [1:0] adap_sync_q;

    logic       por_out_s;
    logic       device_detect_s;
    logic       rstn_out_s;
    logic       adap_rstn_out_s;
    logic       lp;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] cnt_inc;
    logic            reenter;

    logic adapt_rstn_q;
    logic rstn_in_q;
    logic adap_rstn_in_q;
    logic link_up_q;
    logic seq_err_q;

    // Two-flop synchronisers for the asynchronous PHY status inputs.
    // NOTE: reset values are chosen so that a freshly reset sequencer reads
    // "no link, no remote release" (por_out high means power-on reset active).
    always_ff @(posedge clk) begin
        if (rst) begin
            por_sync_q  <= 2'b11;
            det_sync_q  <= 2'b00;
            rstn_sync_q <= 2'b00;
            adap_sync_q <= 2'b00;
        end else begin
            por_sync_q  <= {por_sync_q[0], por_out};
            det_sync_q  <= {det_sync_q[0], device_detect};
            rstn_sync_q <= {rstn_sync_q[0], rstn_out};
            adap_sync_q <= {adap_sync_q[0], adap_rstn_out};
        end
    end

    assign por_out_s       = por_sync_q[1];
    assign device_detect_s = det_sync_q[1];
    assign rstn_out_s      = rstn_sync_q[1];
    assign adap_rstn_out_s = adap_sync_q[1];

    // Master sees link presence as the PHY leaving power-on reset; slave uses detect.
    assign lp = ms_nsl ? ~por_out_s : device_detect_s;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

    // Next-state and counter decode, in transition priority order.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_inc;
        reenter = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else if (restart) begin
            state_d = ST_WAIT_LINK;
            reenter = 1'b1;
        end else if (!lp && (state_q inside {[ST_PHY_RST:ST_LINK_UP]})) begin
            state_d = ST_WAIT_LINK;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_LINK;
                ST_WAIT_LINK: begin
                    if (!lp)                     cnt_d   = '0;
                    else if (cnt_q == DBNC_LAST) state_d = ST_PHY_RST;
                end
                ST_PHY_RST: begin
                    if (cnt_q == PHY_LAST) state_d = ST_RSTN_REL;
                end
                ST_RSTN_REL: begin
                    if (rstn_out_s)             state_d = ST_ADAP_DLY;
                    else if (cnt_q == TMO_LAST) state_d = ST_ERROR;
                end
                ST_ADAP_DLY: begin
                    if (!rstn_out_s)             state_d = ST_WAIT_LINK;
                    else if (cnt_q == ADAP_LAST) state_d = ST_ADAP_REL;
                end
                ST_ADAP_REL: begin
                    if (!rstn_out_s)            state_d = ST_WAIT_LINK;
                    else if (adap_rstn_out_s)   state_d = ST_LINK_UP;
                    else if (cnt_q == TMO_LAST) state_d = ST_ERROR;
                end
                ST_LINK_UP: begin
                    if (!rstn_out_s || !adap_rstn_out_s) state_d = ST_WAIT_LINK;
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase
        end

        // Any state entry, including a restart back into WAIT_LINK, restarts the count.
        if (reenter || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    // State, counter and outputs all load from the next-state decode on the same edge.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            adapt_rstn_q   <= 1'b0;
            rstn_in_q      <= 1'b0;
            adap_rstn_in_q <= 1'b0;
            link_up_q      <= 1'b0;
            seq_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            adapt_rstn_q   <= state_d inside {[ST_PHY_RST:ST_LINK_UP]};
            rstn_in_q      <= state_d inside {[ST_RSTN_REL:ST_LINK_UP]};
            adap_rstn_in_q <= state_d inside {ST_ADAP_REL, ST_LINK_UP};
            link_up_q      <= (state_d == ST_LINK_UP);
            seq_err_q      <= (state_d == ST_ERROR);
        end
    end

    assign adapt_rstn   = adapt_rstn_q;
    assign rstn_in      = rstn_in_q;
    assign adap_rstn_in = adap_rstn_in_q;
    assign link_up      = link_up_q;
    assign seq_err      = seq_err_q;
    assign seq_state    = state_q;

endmodule
